mash_acc_chain: RTL and testbench
=================================

MASH_ACC_CHAIN -- requirements
Module: mash_acc_chain

Interface
REQ-001 The block SHALL have parameter P_ACC_WIDTH, default 16, giving the accumulator and fractional word width in bits (legal range 4..32).
REQ-002 The block SHALL have port i_clk, input, 1 bit: the clock.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port i_en, input, 1 bit: modulator advance enable.
REQ-005 The block SHALL have port i_clr, input, 1 bit: synchronous clear of accumulator state.
REQ-006 The block SHALL have port i_frac, input, P_ACC_WIDTH bits: fractional control word.
REQ-007 The block SHALL have port i_frac_valid, input, 1 bit: i_frac is offered.
REQ-008 The block SHALL have port o_frac_ready, output, 1 bit: the block can accept i_frac.
REQ-009 The block SHALL have port o_quantize1, output, 1 bit: stage-1 carry, feeding the noise-cancellation network.
REQ-010 The block SHALL have port o_quantize2, output, 1 bit: stage-2 carry.
REQ-011 The block SHALL have port o_quantize3, output, 1 bit: stage-3 carry.

Function
REQ-012 The block SHALL hold an active word r_frac_act and a one-deep pending word r_frac_pend with flag r_pend_full.
REQ-013 o_frac_ready SHALL equal ~r_pend_full (combinational); a transfer occurs on any edge where i_frac_valid=1 and o_frac_ready=1, loading r_frac_pend and setting r_pend_full.
REQ-014 On an edge where i_en=1 and r_pend_full=1, the pending word SHALL move to r_frac_act, r_pend_full SHALL clear, and the new r_frac_act SHALL first be used on the following enabled edge.
REQ-015 Pending-to-active move and a new acceptance SHALL NOT coincide, because ready is low while the pending word is full; i_frac_valid held with ready low SHALL NOT alter any state.
REQ-016 Stage 1 SHALL compute {c1,acc1} <= acc1 + r_frac_act + d on each edge with i_en=1, where d is the dither bit (REQ-026/027); sums wrap modulo 2^P_ACC_WIDTH.
REQ-017 Stage 2 SHALL compute {c2,acc2} <= acc2 + acc1, using the registered acc1 value before the same edge.
REQ-018 Stage 3 SHALL compute {c3,acc3} <= acc3 + acc2, using the registered acc2 value before the same edge.
REQ-019 o_quantize1/2/3 SHALL be registered c1/c2/c3; the latency from a r_frac_act change to its effect SHALL be 1 enabled edge on o_quantize1, 2 on o_quantize2 and 3 on o_quantize3.
REQ-020 On edges with i_en=0, acc1..acc3 and the LFSR SHALL hold, and o_quantize1..3 SHALL load 0.
REQ-021 i_clr=1 SHALL have priority over i_en: acc1..acc3, o_quantize1..3 and the LFSR SHALL return to reset values; r_frac_act, r_frac_pend, r_pend_full and the handshake SHALL be unaffected.
REQ-022 With r_frac_act = F and no dither, the count of o_quantize1 ones over 2^P_ACC_WIDTH consecutive enabled edges SHALL equal F exactly.

Reset
REQ-023 Asserting i_rst_n low SHALL immediately clear acc1..acc3, o_quantize1..3, r_frac_act, r_frac_pend and r_pend_full to 0, so o_frac_ready=1.
REQ-024 Asserting i_rst_n low SHALL load the LFSR with seed 16'hACE1.
REQ-025 Reset asserted mid-operation SHALL discard any pending word.

Configuration
REQ-026 With macro MASH_DITHER_EN defined, a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) SHALL advance on each enabled edge, and d SHALL equal LFSR bit 0.
REQ-027 Without MASH_DITHER_EN, d SHALL be constant 0 and no LFSR logic SHALL be present.

Verification
REQ-028 The bench SHALL cover reset: assert reset mid-run -> all o_quantize* = 0 and o_frac_ready = 1 without waiting for a clock edge.
REQ-029 The bench SHALL cover a half-scale word: P_ACC_WIDTH=4, load F=8, i_en=1, no dither -> o_quantize1 = 0,1,0,1,... and exactly 8 ones per 16 edges.
REQ-030 The bench SHALL cover the minimum word: P_ACC_WIDTH=4, F=1 -> o_quantize1 high exactly once per 16 enabled edges, on the 16th.
REQ-031 The bench SHALL cover back-to-back loads: push F=4 then F=12, i_en=1 -> ready drops for 1 cycle after the first push, and the second word is accepted the cycle after the transfer.
REQ-032 The bench SHALL cover enable pause and clear: i_en=0 for 5 cycles mid-run -> o_quantize* = 0 during the pause and the sequence resumes unchanged; i_clr pulse -> accumulators 0 while r_frac_act is retained.
REQ-033 The bench SHALL cover dither: with MASH_DITHER_EN and F=0 -> o_quantize1 is not constantly 0 within 64 edges; without the macro -> it stays 0.

Source files
------------

// File: rtl/mash_acc_chain.sv
// mash_acc_chain: three cascaded first-order accumulators forming the core of a
// MASH 1-1-1 sigma-delta modulator. Carries from each stage are registered
// and presented on o_quantize1..3 for an external noise-cancellation network.
// The fractional word is loaded through a one-deep valid/ready buffer. The
// buffered word only becomes active on an enabled edge, so a new word never
// lands in the middle of an edge's arithmetic.
// Optional feature: define MASH_DITHER_EN to add a 16-bit LFSR whose bit 0 is
// injected as the stage-1 carry-in (dither). When the macro is undefined, no
// LFSR logic is built and the carry-in is tied to 0.
module mash_acc_chain #(
    parameter int P_ACC_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic                   i_clr,
    input  logic [P_ACC_WIDTH-1:0] i_frac,
    input  logic                   i_frac_valid,
    output logic                   o_frac_ready,
    output logic                   o_quantize1,
    output logic                   o_quantize2,
    output logic                   o_quantize3
);

    // Sums carry one extra bit so the stage carry falls out as the MSB.
    localparam int SW = P_ACC_WIDTH + 1;

    logic [P_ACC_WIDTH-1:0] frac_act_q;
    logic [P_ACC_WIDTH-1:0] frac_pend_q;
    logic                   pend_full_q;

    logic [P_ACC_WIDTH-1:0] acc_q [3];
    logic [SW-1:0]          sum   [3];
    logic [2:0]             quant_q;
    logic                   dither;

    // The buffer is either empty (it can accept) or full (it waits for an enabled edge).
    assign o_frac_ready = ~pend_full_q;

    assign o_quantize1 = quant_q[0];
    assign o_quantize2 = quant_q[1];
    assign o_quantize3 = quant_q[2];

`ifdef MASH_DITHER_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting towards bit 0.
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign dither = lfsr_q[0];

    // The LFSR advances together with the accumulators and is reseeded by clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr_q <= 16'hACE1;
        end else if (i_clr) begin
            lfsr_q <= 16'hACE1;
        end else if (i_en) begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign dither = 1'b0;
`endif

    // Stage 0 adds the active word plus dither. Each later stage integrates the
    // residue that the stage before it held prior to this edge.
    for (genvar gi = 0; gi < 3; gi++) begin : g_stage
        logic [SW-1:0] addend;
        if (gi == 0) begin : g_first
            assign addend = SW'(frac_act_q) + SW'(dither);
        end else begin : g_cascade
            assign addend = SW'(acc_q[gi-1]);
        end
        assign sum[gi] = SW'(acc_q[gi]) + addend;
    end

    // The buffer is never filled and drained on the same edge. Clear leaves the buffer alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frac_act_q  <= '0;
            frac_pend_q <= '0;
            pend_full_q <= 1'b0;
        end else if (i_frac_valid && !pend_full_q) begin
            frac_pend_q <= i_frac;
            pend_full_q <= 1'b1;
        end else if (i_en && pend_full_q) begin
            frac_act_q  <= frac_pend_q;
            pend_full_q <= 1'b0;
        end
    end

    // Accumulator chain: clear has priority, enable integrates, and an idle edge holds the residue with zero carries.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 3; i++) begin
                acc_q[i] <= '0;
            end
            quant_q <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < 3; i++) begin
                acc_q[i] <= '0;
            end
            quant_q <= '0;
        end else if (i_en) begin
            for (int i = 0; i < 3; i++) begin
                acc_q[i]   <= sum[i][P_ACC_WIDTH-1:0];
                quant_q[i] <= sum[i][P_ACC_WIDTH];
            end
        end else begin
            quant_q <= '0;
        end
    end

endmodule

// File: tb/tb_mash_acc_chain.sv
// tb_mash_acc_chain: directed and randomized checks of mash_acc_chain at
// P_ACC_WIDTH=4. A behavioural model tracks the modulo-16 sums, the carries
// and the one-deep load buffer. All comparisons go through check_val.
module tb_mash_acc_chain;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk;
    logic         i_rst_n;
    logic         i_en;
    logic         i_clr;
    logic [W-1:0] i_frac;
    logic         i_frac_valid;
    logic         o_frac_ready;
    logic         o_quantize1;
    logic         o_quantize2;
    logic         o_quantize3;

    mash_acc_chain #(.P_ACC_WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_en         (i_en),
        .i_clr        (i_clr),
        .i_frac       (i_frac),
        .i_frac_valid (i_frac_valid),
        .o_frac_ready (o_frac_ready),
        .o_quantize1  (o_quantize1),
        .o_quantize2  (o_quantize2),
        .o_quantize3  (o_quantize3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    vectors;
    int    miscompares;
    string phase;

    // Reference state
    int m_acc [3];
    int m_q   [3];
    int m_act;
    int m_pend [$];
    int m_lfsr;

    task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s/%s: got %0d expected %0d", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0;
            m_q[i]   = 0;
        end
        m_act = 0;
        m_pend.delete();
        m_lfsr = 16'hACE1;
    endtask

    // One clock edge of the spec's behaviour. Arithmetic uses the old active word.
    task automatic model_edge(input bit en, input bit clr, input bit valid, input int frac);
        int  s [3];
        int  d;
        int  fb;
        bit  ready;
        ready = (m_pend.size() == 0);
`ifdef MASH_DITHER_EN
        d = m_lfsr % 2;
`else
        d = 0;
`endif
        if (clr) begin
            for (int i = 0; i < 3; i++) begin
                m_acc[i] = 0;
                m_q[i]   = 0;
            end
            m_lfsr = 16'hACE1;
        end else if (en) begin
            s[0] = m_acc[0] + m_act + d;
            s[1] = m_acc[1] + m_acc[0];
            s[2] = m_acc[2] + m_acc[1];
            for (int i = 0; i < 3; i++) begin
                m_q[i]   = s[i] / M;
                m_acc[i] = s[i] % M;
            end
            fb     = ((m_lfsr) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
            m_lfsr = (m_lfsr >> 1) | (fb << 15);
        end else begin
            for (int i = 0; i < 3; i++) m_q[i] = 0;
        end
        if (valid && ready) begin
            m_pend.push_back(frac);
        end else if (en && m_pend.size() > 0) begin
            m_act = m_pend.pop_front();
        end
    endtask

    // Apply the current inputs for one edge, then compare every output with the model.
    task automatic step();
        bit en, clr, valid;
        int frac;
        en    = i_en;
        clr   = i_clr;
        valid = i_frac_valid;
        frac  = int'(i_frac);
        @(posedge clk);
        model_edge(en, clr, valid, frac);
        #1;
        check_val("q1", o_quantize1, m_q[0]);
        check_val("q2", o_quantize2, m_q[1]);
        check_val("q3", o_quantize3, m_q[2]);
        check_val("ready", o_frac_ready, (m_pend.size() == 0) ? 1 : 0);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic do_reset();
        i_rst_n = 1'b0;
        #1;
        check_val("rst_q1", o_quantize1, 0);
        check_val("rst_q2", o_quantize2, 0);
        check_val("rst_q3", o_quantize3, 0);
        check_val("rst_ready", o_frac_ready, 1);
        model_reset();
        i_en         = 1'b0;
        i_clr        = 1'b0;
        i_frac_valid = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    // Offer a word while the chain is idle so it sits in the pending buffer.
    task automatic load_word(input int f);
        i_en         = 1'b0;
        i_frac_valid = 1'b1;
        i_frac       = W'(f);
        step();
        i_frac_valid = 1'b0;
    endtask

    initial begin
        int ones;
        vectors      = 0;
        miscompares  = 0;
        i_en         = 1'b0;
        i_clr        = 1'b0;
        i_frac       = '0;
        i_frac_valid = 1'b0;
        i_rst_n      = 1'b1;
        model_reset();
        #1;
        phase = "reset";
        do_reset();

        // Half-scale word: carries alternate and give 8 per 16 edges.
        phase = "half";
        load_word(8);
        i_en = 1'b1;
        step();                      // word becomes active; this edge still adds 0
        ones = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            ones += int'(o_quantize1);
`ifndef MASH_DITHER_EN
            check_val("half_q1", o_quantize1, (k % 2 == 0) ? 1 : 0);
`endif
        end
`ifndef MASH_DITHER_EN
        check_val("half_ones", ones, 8);
`endif

        // Pause: carries go to 0 and the sequence resumes where it left off.
        phase = "pause";
        i_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("pause_q1", o_quantize1, 0);
        end
        i_en = 1'b1;
        for (int k = 17; k <= 24; k++) begin
            step();
`ifndef MASH_DITHER_EN
            check_val("resume_q1", o_quantize1, (k % 2 == 0) ? 1 : 0);
`endif
        end

        // Clear: accumulators restart from 0 but the active word (8) is kept.
        phase = "clear";
        i_clr = 1'b1;
        step();
        i_clr = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                i_frac_valid = 1'b1;
                i_frac       = W'(1);
            end
            step();
`ifndef MASH_DITHER_EN
            check_val("clr_q1", o_quantize1, (k % 2 == 0) ? 1 : 0);
`endif
        end
        i_frac_valid = 1'b0;

        // Mid-run reset with a word still pending: that word must be discarded.
        phase = "midreset";
        #2;
        do_reset();
        i_en = 1'b1;
        for (int k = 0; k < 4; k++) step();

        // Minimum word: one carry per 16 edges, on the 16th.
        phase = "min";
        load_word(1);
        i_en = 1'b1;
        step();
        ones = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            ones += int'(o_quantize1);
`ifndef MASH_DITHER_EN
            check_val("min_q1", o_quantize1, (k == 16) ? 1 : 0);
`endif
        end
`ifndef MASH_DITHER_EN
        check_val("min_ones", ones, 1);
`endif

        // Back-to-back loads: the second word waits one cycle for the buffer to drain.
        phase = "b2b";
        #2;
        do_reset();
        i_en         = 1'b1;
        i_frac_valid = 1'b1;
        i_frac       = W'(4);
        step();
        check_val("b2b_after_first", o_frac_ready, 0);
        i_frac = W'(12);
        step();
        check_val("b2b_after_move", o_frac_ready, 1);
        step();
        check_val("b2b_after_second", o_frac_ready, 0);
        i_frac_valid = 1'b0;
        for (int k = 0; k < 12; k++) step();

        // Dither: with F=0, carries appear only if dither is present.
        phase = "dither";
        #2;
        do_reset();
        i_en = 1'b1;
        ones = 0;
        for (int k = 0; k < 64; k++) begin
            step();
            ones += int'(o_quantize1);
        end
`ifdef MASH_DITHER_EN
        check_val("dither_active", (ones > 0) ? 1 : 0, 1);
`else
        check_val("dither_absent", ones, 0);
`endif

        // Randomized traffic against the model, with occasional asynchronous resets.
        phase = "random";
        for (int n = 0; n < 600; n++) begin
            i_en         = ($urandom_range(0, 99) < 80);
            i_clr        = ($urandom_range(0, 99) < 3);
            i_frac_valid = ($urandom_range(0, 99) < 30);
            i_frac       = W'($urandom_range(0, M - 1));
            step();
            if ($urandom_range(0, 199) == 0) begin
                #2;
                do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
